// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit behind a prev/next
// valid-stall handshake. One radix-2 step per cycle on a shared 33-bit adder.
// Optional build macro MULDIV_EARLY_OUT_EN: zero operands, divide by zero and
// signed overflow finish one cycle after acceptance instead of 32.
module muldiv_sequencer #(
  parameter int DATA_WIDTH              = 32,
  parameter int REGISTER_INDEXING_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               prev_done,
  output logic                               stall_prev,
  output logic                               done_next,
  input  logic                               next_stall,
  input  logic [DATA_WIDTH-1:0]              lhs_in,
  input  logic [DATA_WIDTH-1:0]              rhs_in,
  input  logic [2:0]                         funct_3_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic [DATA_WIDTH-1:0]              result_data_out,
  output logic                               busy
);
  localparam int DW = DATA_WIDTH;
  localparam int RW = REGISTER_INDEXING_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  logic [4:0]    count_q;
  logic [2:0]    op_q;
  logic          neg_q;
  logic [DW-1:0] hi_q, lo_q, opb_q, result_q;
  logic [RW-1:0] wr_q;

  logic          transfer_prev, transfer_next;

  assign done_next          = (state_q == DONE);
  assign busy               = (state_q != IDLE);
  assign result_data_out    = result_q;
  assign write_register_out = wr_q;

  // Handshake; stall_prev is forced high during reset independent of the clock.
  always_comb begin
    transfer_next = (state_q == DONE) && !next_stall;
    stall_prev    = !rst || (state_q == BUSY) || ((state_q == DONE) && next_stall);
    transfer_prev = prev_done && !stall_prev;
  end

  logic          lhs_signed, rhs_signed, lhs_neg, rhs_neg, rhs_zero, neg_in;
  logic [DW-1:0] lhs_mag, rhs_mag;

  // Operand decode: magnitudes plus the sign to apply to the final result.
  always_comb begin
    lhs_signed = funct_3_in[2] ? !funct_3_in[0] : (funct_3_in[1:0] != 2'b11);
    rhs_signed = funct_3_in[2] ? !funct_3_in[0] : !funct_3_in[1];
    lhs_neg    = lhs_signed && lhs_in[DW-1];
    rhs_neg    = rhs_signed && rhs_in[DW-1];
    lhs_mag    = lhs_neg ? -lhs_in : lhs_in;
    rhs_mag    = rhs_neg ? -rhs_in : rhs_in;
    rhs_zero   = (rhs_in == '0);
    case (funct_3_in)
      3'b100:         neg_in = (lhs_neg ^ rhs_neg) && !rhs_zero; // x/0 stays all-ones
      3'b110:         neg_in = lhs_neg;                          // remainder follows dividend
      3'b101, 3'b111: neg_in = 1'b0;
      default:        neg_in = lhs_neg ^ rhs_neg;
    endcase
  end

  logic [DW:0]     add_a, add_b;
  logic            add_cin;
  logic [DW+1:0]   add_sum;
  logic [DW-1:0]   hi_nxt, lo_nxt;

  // One iteration: shift-add multiply or restoring-divide trial subtraction.
  always_comb begin
    if (op_q[2]) begin
      add_a   = {hi_q, lo_q[DW-1]};
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, opb_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(DW+1){1'b0}}, add_cin};
    if (op_q[2]) begin
      // carry out set means no borrow: the divisor fits, quotient bit is 1
      hi_nxt = add_sum[DW+1] ? add_sum[DW-1:0] : add_a[DW-1:0];
      lo_nxt = {lo_q[DW-2:0], add_sum[DW+1]};
    end else begin
      hi_nxt = add_sum[DW:1];
      lo_nxt = {add_sum[0], lo_q[DW-1:1]};
    end
  end

  logic [2*DW-1:0] prod, prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix, final_result;

  // Sign correction and result selection for the last iteration.
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_nxt : lo_nxt;
    rem_fix  = neg_q ? -hi_nxt : hi_nxt;
    case (op_q)
      3'b000:                 final_result = prod_fix[DW-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_fix[2*DW-1:DW];
      3'b100, 3'b101:         final_result = quo_fix;
      default:                final_result = rem_fix;
    endcase
  end

  logic early_stop;
`ifdef MULDIV_EARLY_OUT_EN
  logic          early_q, early_in, sgn_ovf;
  logic [DW-1:0] early_result;

  // Trivial cases whose result is known at acceptance.
  always_comb begin
    sgn_ovf  = funct_3_in[2] && !funct_3_in[0] &&
               (lhs_in == {1'b1, {(DW-1){1'b0}}}) && (rhs_in == '1);
    early_in = (lhs_in == '0) || rhs_zero || sgn_ovf;
    early_result = '0;
    if (funct_3_in[2]) begin
      if (rhs_zero)     early_result = funct_3_in[1] ? lhs_in : '1;
      else if (sgn_ovf) early_result = funct_3_in[1] ? '0 : lhs_in;
    end
  end
  assign early_stop = early_q;
`else
  assign early_stop = 1'b0;
`endif

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      wr_q     <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q  <= 1'b0;
`endif
    end else if (transfer_prev) begin
      // transfer_prev is only possible in IDLE, or in DONE while the result leaves
      state_q <= BUSY;
      count_q <= '0;
      op_q    <= funct_3_in;
      neg_q   <= neg_in;
      hi_q    <= '0;
      lo_q    <= lhs_mag;
      opb_q   <= rhs_mag;
      wr_q    <= write_register_in;
`ifdef MULDIV_EARLY_OUT_EN
      early_q <= early_in;
      if (early_in) result_q <= early_result;
`endif
    end else begin
      case (state_q)
        BUSY: begin
          if (early_stop) begin
            state_q <= DONE;
          end else begin
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) begin
              result_q <= final_result;
              state_q  <= DONE;
            end
          end
        end
        DONE: if (transfer_next) state_q <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer; expected results
// come from a behavioural RV32M model and are checked as results leave the DUT.
module tb_muldiv_sequencer;
  logic        clk = 1'b0, rst = 1'b1, prev_done = 1'b0, next_stall = 1'b0;
  logic        stall_prev, done_next, busy;
  logic [31:0] lhs_in = '0, rhs_in = '0, result_data_out;
  logic [2:0]  funct_3_in = '0;
  logic [4:0]  write_register_in = '0, write_register_out;

  int n_cmp = 0, n_err = 0, cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wr;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];
  bit   done_seen = 1'b0;

  muldiv_sequencer #(.DATA_WIDTH(32), .REGISTER_INDEXING_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .prev_done(prev_done), .stall_prev(stall_prev),
    .done_next(done_next), .next_stall(next_stall), .lhs_in(lhs_in), .rhs_in(rhs_in),
    .funct_3_in(funct_3_in), .write_register_in(write_register_in),
    .write_register_out(write_register_out), .result_data_out(result_data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sbb = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sbb; return p[31:0]; end
      3'd1: begin p = sa * sbb; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 0 || b == 0 ||
        (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 32;
  endfunction

  // Output monitor: result/destination checked every cycle it is offered.
  always @(negedge clk) begin
    if (!rst) begin
      done_seen = 1'b0;
    end else if (done_next) begin
      if (sbq.size() == 0) begin
        check("spurious_done", {63'b0, done_next}, 64'd0);
      end else begin
        if (!done_seen) check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
        check("result", {32'b0, result_data_out}, {32'b0, sbq[0].res});
        check("dest", {59'b0, write_register_out}, {59'b0, sbq[0].wr});
        if (!next_stall) void'(sbq.pop_front());
      end
      done_seen = 1'b1;
    end else begin
      done_seen = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wr, input int hold, output int waited);
    exp_t e;
    @(negedge clk);
    prev_done = 1'b1; funct_3_in = f; lhs_in = a; rhs_in = b; write_register_in = wr;
    waited = 0;
    #1;
    while (stall_prev && waited < 300) begin
      @(negedge clk); #1; waited++;
    end
    if (stall_prev) begin
      check("accept_timeout", {63'b0, stall_prev}, 64'd0);
      prev_done = 1'b0;
      return;
    end
    e.res = ref_op(f, a, b); e.wr = wr; e.acc = cyc + 1; e.lat = exp_lat(f, a, b);
    sbq.push_back(e);
    @(posedge clk);
    // keep offering junk while busy: it must not disturb the latched operation
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      lhs_in = $urandom; rhs_in = $urandom; funct_3_in = 3'($urandom);
      write_register_in = 5'($urandom);
    end
    @(negedge clk);
    prev_done = 1'b0; lhs_in = $urandom; rhs_in = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  typedef struct { logic [2:0] f; logic [31:0] a, b; } op_t;
  op_t dirs[$] = '{
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'd2},         '{3'd6, 32'hFFFF_FFF9, 32'd2},
    '{3'd5, 32'd5, 32'd0},                 '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF}, '{3'd4, 32'hFFFF_FFF9, 32'd0},
    '{3'd7, 32'h1234_5678, 32'd0},         '{3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
    '{3'd0, 32'd0, 32'hDEAD_BEEF},         '{3'd5, 32'd0, 32'd9}
  };

  initial begin
    int w, hold;
    logic [2:0] f;
    logic [31:0] a, b;
    #1 rst = 1'b0;
    #11;
    check("rst_done", {63'b0, done_next}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_stall", {63'b0, stall_prev}, 64'd1);
    check("rst_result", {32'b0, result_data_out}, 64'd0);
    check("rst_dest", {59'b0, write_register_out}, 64'd0);
    @(negedge clk); rst = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 4, w);
    check("first_accept_wait", 64'(w), 64'd0);
    drain();

    foreach (dirs[i]) begin
      hold = (exp_lat(dirs[i].f, dirs[i].a, dirs[i].b) == 32) ? 3 : 0;
      issue(dirs[i].f, dirs[i].a, dirs[i].b, 5'(i + 4), hold, w);
    end
    drain();

    // Downstream stall in DONE with a new operation waiting.
    issue(3'd5, 32'd1000, 32'd7, 5'd17, 0, w);
    next_stall = 1'b1;
    w = 0;
    while (!done_next && w < 100) begin @(negedge clk); w++; end
    check("stall_wait_done", {63'b0, done_next}, 64'd1);
    fork
      issue(3'd6, 32'hFFFF_FF00, 32'd7, 5'd21, 0, w);
      begin
        repeat (10) begin
          @(negedge clk); #1;
          check("stall_prev_held", {63'b0, stall_prev}, 64'd1);
        end
        @(negedge clk); next_stall = 1'b0;
      end
    join
    drain();

    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      hold = (exp_lat(f, a, b) == 32) ? 2 : 0;
      issue(f, a, b, 5'($urandom), hold, w);
    end
    drain();

    // Reset mid-operation at iteration count 15.
    issue(3'd5, 32'd1000, 32'd7, 5'd9, 0, w);
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_done", {63'b0, done_next}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_stall", {63'b0, stall_prev}, 64'd1);
    check("midrst_result", {32'b0, result_data_out}, 64'd0);
    check("midrst_dest", {59'b0, write_register_out}, 64'd0);
    sbq.delete();
    @(negedge clk); rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", {63'b0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
